// File: rtl/fpu_types_pkg.sv
// fpu_types_pkg: shared half-precision constants and the multiplier status-flag type
package fpu_types_pkg;
  localparam int HALF_FLOAT_W = 16;
  localparam int HALF_EXPONENT_W = 5;
  localparam int HALF_FRACTION_W = 10;
  localparam logic [HALF_FLOAT_W-1:0] HALF_ZERO = 16'h0000;
  localparam logic [HALF_FLOAT_W-1:0] HALF_ZERON = 16'h8000;
  localparam logic [HALF_EXPONENT_W-1:0] HALF_EXP_ALL1 = 5'h1F;
  typedef struct packed {
    logic nv;
    logic of;
    logic ufz;
  } mult_flags_t;
endpackage

// File: rtl/fp16_mult_issue_stage_if.sv
// fp16_mult_issue_stage_if: issue-side, result-side and multiplier-side signals; slave = stage view, master = surroundings
interface fp16_mult_issue_stage_if #(parameter int TAG_W = 4);
  import fpu_types_pkg::*;
  logic in_valid;
  logic in_ready;
  logic [HALF_FLOAT_W-1:0] in_a;
  logic [HALF_FLOAT_W-1:0] in_b;
  logic [TAG_W-1:0] in_tag;
  logic [HALF_FLOAT_W-1:0] mul_float1;
  logic [HALF_FLOAT_W-1:0] mul_float2;
  logic [HALF_FLOAT_W-1:0] mul_product;
  logic out_valid;
  logic out_ready;
  logic [HALF_FLOAT_W-1:0] out_product;
  logic [TAG_W-1:0] out_tag;
  mult_flags_t out_flags;
  modport slave (
    input in_valid, in_a, in_b, in_tag, out_ready, mul_product,
    output in_ready, out_valid, out_product, out_tag, out_flags, mul_float1, mul_float2
  );
  modport master (
    output in_valid, in_a, in_b, in_tag, out_ready, mul_product,
    input in_ready, out_valid, out_product, out_tag, out_flags, mul_float1, mul_float2
  );
endinterface

// File: rtl/fp16_operand_fifo.sv
// fp16_operand_fifo: circular operand buffer (CLK/RST async high, flush sync clear, push/pop, wdata/rdata, full/empty)
module fp16_operand_fifo #(
  parameter int DEPTH = 4,
  parameter int W = 36
) (
  input  logic CLK,
  input  logic RST,
  input  logic flush,
  input  logic push,
  input  logic pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic full,
  output logic empty
);
  localparam int AW = $clog2(DEPTH);
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [AW:0] count;
  logic [W-1:0] mem [DEPTH];
  logic wr_en, rd_en;
  assign full = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  assign rdata = mem[rd_ptr];
  assign wr_en = push & !full;
  assign rd_en = pop & !empty;
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(wr_en) - (AW+1)'(rd_en);
    end
  always_ff @(posedge CLK)
    if (wr_en && !flush) mem[wr_ptr] <= wdata;
endmodule

// File: rtl/fp16_mult_issue_stage.sv
// fp16_mult_issue_stage: queues FP16 operand pairs, drives the external multiplier, registers product/tag/{NV,OF,UFZ}; ports CLK, RST (async high), flush, io (slave), perf_ops/perf_stall when FP16_MULT_PERF_CNT_EN is defined
module fp16_mult_issue_stage
  import fpu_types_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int TAG_W = 4
) (
  input logic CLK,
  input logic RST,
  input logic flush,
  fp16_mult_issue_stage_if.slave io
`ifdef FP16_MULT_PERF_CNT_EN
  ,
  output logic [15:0] perf_ops,
  output logic [15:0] perf_stall
`endif
);
  typedef struct packed {
    logic [HALF_FLOAT_W-1:0] a;
    logic [HALF_FLOAT_W-1:0] b;
    logic [TAG_W-1:0] tag;
  } half_op_t;
  typedef enum logic {EMPTY, FULL} state_t;
  function automatic mult_flags_t classify(logic [15:0] a, logic [15:0] b, logic [15:0] p);
    logic a_fin, b_fin, a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    a_fin = a[14:10] != HALF_EXP_ALL1;
    b_fin = b[14:10] != HALF_EXP_ALL1;
    a_nan = !a_fin && a[9:0] != '0;
    b_nan = !b_fin && b[9:0] != '0;
    a_inf = !a_fin && a[9:0] == '0;
    b_inf = !b_fin && b[9:0] == '0;
    a_zero = a[14:0] == '0;
    b_zero = b[14:0] == '0;
    classify.nv = a_nan | b_nan | (a_zero & b_inf) | (a_inf & b_zero);
    classify.of = a_fin & b_fin & (p[14:10] == HALF_EXP_ALL1);
    classify.ufz = a_fin & b_fin & !a_zero & !b_zero & (p[14:0] == '0);
  endfunction
  half_op_t wr_op, head;
  state_t state;
  logic full, empty, push, load;
  logic [HALF_FLOAT_W-1:0] prod_q;
  logic [TAG_W-1:0] tag_q;
  mult_flags_t flags_q;
  assign wr_op = '{a: io.in_a, b: io.in_b, tag: io.in_tag};
  assign io.in_ready = !full;
  assign push = io.in_valid & !full;
  assign load = !empty & (state == EMPTY | io.out_ready);
  fp16_operand_fifo #(.DEPTH(DEPTH), .W($bits(half_op_t))) u_fifo (
    .CLK(CLK),
    .RST(RST),
    .flush(flush),
    .push(push),
    .pop(load),
    .wdata(wr_op),
    .rdata(head),
    .full(full),
    .empty(empty)
  );
  assign io.mul_float1 = empty ? HALF_ZERO : head.a;
  assign io.mul_float2 = empty ? HALF_ZERO : head.b;
  assign io.out_valid = state == FULL;
  assign io.out_product = prod_q;
  assign io.out_tag = tag_q;
  assign io.out_flags = flags_q;
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      state <= EMPTY;
      prod_q <= '0;
      tag_q <= '0;
      flags_q <= '0;
    end else if (flush) begin
      state <= EMPTY;
    end else if (load) begin
      state <= FULL;
      prod_q <= io.mul_product;
      tag_q <= head.tag;
      flags_q <= classify(head.a, head.b, io.mul_product);
    end else if (io.out_ready) begin
      state <= EMPTY;
    end
`ifdef FP16_MULT_PERF_CNT_EN
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      perf_ops <= '0;
      perf_stall <= '0;
    end else if (flush) begin
      perf_ops <= '0;
      perf_stall <= '0;
    end else begin
      if (load && perf_ops != 16'hFFFF) perf_ops <= perf_ops + 1'b1;
      if (io.out_valid && !io.out_ready && perf_stall != 16'hFFFF) perf_stall <= perf_stall + 1'b1;
    end
`endif
endmodule

// File: tb/tb_fp16_mult_issue_stage.sv
// tb_fp16_mult_issue_stage: directed self-checking bench with a lookup multiplier stub
module tb_fp16_mult_issue_stage;
  import fpu_types_pkg::*;
  logic CLK = 1'b0;
  logic RST;
  logic flush;
  int n_chk = 0;
  int n_fail = 0;
  fp16_mult_issue_stage_if #(.TAG_W(4)) io ();
`ifdef FP16_MULT_PERF_CNT_EN
  logic [15:0] perf_ops, perf_stall;
`endif
  fp16_mult_issue_stage #(.DEPTH(4), .TAG_W(4)) dut (
    .CLK(CLK),
    .RST(RST),
    .flush(flush),
    .io(io.slave)
`ifdef FP16_MULT_PERF_CNT_EN
    ,
    .perf_ops(perf_ops),
    .perf_stall(perf_stall)
`endif
  );
  always #5 CLK = ~CLK;
  function automatic logic [15:0] mul_model(logic [15:0] a, logic [15:0] b);
    case ({a, b})
      32'h3C00_4000: mul_model = 16'h4000;
      32'h7C00_0000: mul_model = 16'hFFFF;
      32'h7BFF_4000: mul_model = 16'h7C00;
      32'h0001_0001: mul_model = 16'h0000;
      default: mul_model = a ^ b;
    endcase
  endfunction
  always_comb io.mul_product = mul_model(io.mul_float1, io.mul_float2);
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic op(input logic [15:0] a, input logic [15:0] b, input logic [3:0] t);
    io.in_valid = 1'b1;
    io.in_a = a;
    io.in_b = b;
    io.in_tag = t;
    tick();
    io.in_valid = 1'b0;
    tick();
  endtask
  initial begin
    io.in_valid = 1'b0;
    io.in_a = '0;
    io.in_b = '0;
    io.in_tag = '0;
    io.out_ready = 1'b0;
    flush = 1'b0;
    RST = 1'b0;
    #1 RST = 1'b1;
    #1;
    chk("rst_in_ready", 32'(io.in_ready), 32'd1);
    chk("rst_out_valid", 32'(io.out_valid), 32'd0);
    chk("rst_product", 32'(io.out_product), 32'd0);
    chk("rst_tag", 32'(io.out_tag), 32'd0);
    chk("rst_flags", 32'(io.out_flags), 32'd0);
    tick();
    RST = 1'b0;
    io.out_ready = 1'b1;
    io.in_valid = 1'b1;
    io.in_a = 16'h3C00;
    io.in_b = 16'h4000;
    io.in_tag = 4'd3;
    tick();
    io.in_valid = 1'b0;
    chk("mul_float1", 32'(io.mul_float1), 32'h3C00);
    chk("mul_float2", 32'(io.mul_float2), 32'h4000);
    chk("op1_valid_early", 32'(io.out_valid), 32'd0);
    tick();
    chk("op1_valid", 32'(io.out_valid), 32'd1);
    chk("op1_product", 32'(io.out_product), 32'h4000);
    chk("op1_tag", 32'(io.out_tag), 32'd3);
    chk("op1_flags", 32'(io.out_flags), 32'b000);
    op(16'h7C00, 16'h0000, 4'd1);
    chk("nv_product", 32'(io.out_product), 32'hFFFF);
    chk("nv_flags", 32'(io.out_flags), 32'b100);
    chk("nv_tag", 32'(io.out_tag), 32'd1);
    op(16'h7BFF, 16'h4000, 4'd2);
    chk("of_product", 32'(io.out_product), 32'h7C00);
    chk("of_flags", 32'(io.out_flags), 32'b010);
    op(16'h0001, 16'h0001, 4'd4);
    chk("ufz_product", 32'(io.out_product), 32'h0000);
    chk("ufz_flags", 32'(io.out_flags), 32'b001);
    tick();
    chk("drained_valid", 32'(io.out_valid), 32'd0);
    io.out_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      io.in_valid = 1'b1;
      io.in_a = 16'h1000 | 16'(i);
      io.in_b = 16'h2000;
      io.in_tag = 4'(i);
      tick();
      chk($sformatf("bp_in_ready_%0d", i), 32'(io.in_ready), (i >= 4) ? 32'd0 : 32'd1);
    end
    io.in_valid = 1'b0;
    chk("bp_head_valid", 32'(io.out_valid), 32'd1);
    chk("bp_head_tag", 32'(io.out_tag), 32'd0);
    chk("bp_head_product", 32'(io.out_product), 32'h3000);
    io.out_ready = 1'b1;
    for (int i = 1; i < 5; i++) begin
      tick();
      chk($sformatf("drain_valid_%0d", i), 32'(io.out_valid), 32'd1);
      chk($sformatf("drain_tag_%0d", i), 32'(io.out_tag), 32'(i));
      chk($sformatf("drain_product_%0d", i), 32'(io.out_product), 32'h3000 + 32'(i));
      chk($sformatf("drain_in_ready_%0d", i), 32'(io.in_ready), 32'd1);
    end
    tick();
    chk("drain_done", 32'(io.out_valid), 32'd0);
    io.out_ready = 1'b0;
    for (int i = 8; i < 12; i++) begin
      io.in_valid = 1'b1;
      io.in_a = 16'h1000 | 16'(i);
      io.in_b = 16'h2000;
      io.in_tag = 4'(i);
      tick();
    end
    io.in_tag = 4'd12;
    flush = 1'b1;
    #1;
    chk("flush_in_ready", 32'(io.in_ready), 32'd1);
    chk("preflush_valid", 32'(io.out_valid), 32'd1);
    tick();
    flush = 1'b0;
    io.in_valid = 1'b0;
    chk("flush_out_valid", 32'(io.out_valid), 32'd0);
    chk("flush_empty", 32'(io.mul_float1), 32'h0000);
    chk("flush_in_ready_after", 32'(io.in_ready), 32'd1);
    io.out_ready = 1'b1;
    tick();
    tick();
    chk("flush_push_dropped", 32'(io.out_valid), 32'd0);
    io.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      io.in_valid = 1'b1;
      io.in_a = 16'h7C00;
      io.in_b = 16'h0000;
      io.in_tag = 4'd7;
      tick();
    end
    io.in_valid = 1'b0;
    chk("pre_rst_valid", 32'(io.out_valid), 32'd1);
    chk("pre_rst_in_ready", 32'(io.in_ready), 32'd0);
    chk("pre_rst_flags", 32'(io.out_flags), 32'b100);
`ifdef FP16_MULT_PERF_CNT_EN
    chk("perf_ops", 32'(perf_ops), 32'd1);
    chk("perf_stall", 32'(perf_stall), 32'd3);
`endif
    #2 RST = 1'b1;
    #1;
    chk("arst_out_valid", 32'(io.out_valid), 32'd0);
    chk("arst_in_ready", 32'(io.in_ready), 32'd1);
    chk("arst_flags", 32'(io.out_flags), 32'd0);
    chk("arst_product", 32'(io.out_product), 32'd0);
    chk("arst_tag", 32'(io.out_tag), 32'd0);
`ifdef FP16_MULT_PERF_CNT_EN
    chk("arst_perf_ops", 32'(perf_ops), 32'd0);
    chk("arst_perf_stall", 32'(perf_stall), 32'd0);
`endif
    tick();
    RST = 1'b0;
    io.out_ready = 1'b1;
    op(16'h3C00, 16'h4000, 4'd5);
    chk("post_rst_product", 32'(io.out_product), 32'h4000);
    chk("post_rst_tag", 32'(io.out_tag), 32'd5);
    tick();
    chk("post_rst_idle", 32'(io.out_valid), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
